memory_interface_arbiter: RTL and testbench
===========================================

# memory_interface_arbiter

Shares one single-port word memory between the phoeniX instruction memory interface (read-only) and data memory interface (read/write). Requests are serialised through a three-state FSM with a data-first priority and a starvation limit for fetches. A per-access timeout counter guarantees forward progress. The block sits between the core's two memory interfaces and the unified memory model or the SoC memory.

## Interface
- `DATA_BURST_LIMIT`, 4: maximum consecutive data grants while a fetch is pending; range 1–15.
- `TIMEOUT_CYCLES`, 255: cycles in BUSY without `memory_ready` before the access is aborted; range 1–255.
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `instruction_enable`  in  1  fetch request; held until `instruction_ready`.
- `instruction_address`  in  32  byte address; bits [1:0] ignored.
- `instruction_ready`  out  1  one-cycle pulse: `instruction_read_data` valid.
- `instruction_read_data`  out  32  fetched word.
- `data_enable`  in  1  data request; held until `data_ready`.
- `data_state`  in  1  `READ`=0, `WRITE`=1.
- `data_address`  in  32  byte address; bits [1:0] ignored.
- `data_frame_mask`  in  4  byte enables:
  - bit3 → [7:0], bit2 → [15:8], bit1 → [23:16], bit0 → [31:24].
- `data_write_data`  in  32  store data.
- `data_ready`  out  1  one-cycle completion pulse (reads and writes).
- `data_read_data`  out  32  loaded word.
- `access_error`  out  1  one-cycle pulse together with `*_ready` when the access timed out.
- `memory_enable`  out  1  memory access active.
- `memory_state`  out  1  `READ`/`WRITE`.
- `memory_address`  out  32  word-aligned address; [1:0] forced to 0.
- `memory_frame_mask`  out  4  byte enables; 4'b1111 for fetches.
- `memory_write_data`  out  32  store data.
- `memory_read_data`  in  32  valid when `memory_ready` is high.
- `memory_ready`  in  1  memory completes the access this cycle.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, sampled at posedge:
  - Only one enable high: grant that requester.
  - Both high: grant data, unless `burst_count` == `DATA_BURST_LIMIT`; then grant instruction.
  - On grant, register address, state, mask and write data into the memory-side registers; move to BUSY_x.
- `burst_count` (4 bits):
  - Increments on each data grant made while `instruction_enable` is high.
  - Clears on any instruction grant.
  - Clears on a data grant made while `instruction_enable` is low.
  - Saturates at `DATA_BURST_LIMIT`.
- BUSY_x:
  - `memory_enable`=1; memory outputs are held stable.
  - `timeout_count` increments each cycle.
  - If `memory_ready`=1: capture `memory_read_data` into the granted requester's `*_read_data`, pulse `*_ready`, clear the timer, go to IDLE.
  - If `timeout_count` reaches `TIMEOUT_CYCLES`: pulse `*_ready` and `access_error`, leave `*_read_data` unchanged, drop `memory_enable`, go to IDLE.
- Fetches always use `memory_state`=READ and mask 4'b1111.
- A write completes with `data_ready`; `data_read_data` is not updated on writes.
- If an enable is still high in the cycle its `*_ready` is high, the arbiter treats it as a new request (back-to-back streaming).
- Requests change only in IDLE; input changes during BUSY are ignored.
- Reset returns all of the following to their reset values, whether in IDLE or mid-access:
  - FSM to IDLE.
  - `burst_count` and `timeout_count` to 0.
  - All `*_ready`, `access_error` and `memory_enable` to 0.
  - `memory_*` and `*_read_data` registers to 0.
- A memory write interrupted by reset is abandoned; the arbiter does not retry it.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Cycle 0: request sampled in IDLE.
- Cycle 1: `memory_enable` high.
- With `memory_ready` high in cycle 1, `*_ready` and the read data appear in cycle 2.
- Minimum latency: 2 cycles. Each extra memory wait cycle adds 1.
- Back-to-back throughput: one access per 2 cycles.
- Timeout: `*_ready` and `access_error` assert `TIMEOUT_CYCLES`+1 cycles after the grant.
- `memory_enable` deasserts in the same cycle `*_ready` asserts.

## Test plan
- Single fetch:
  - Stimulus: `instruction_enable`=1, address 0x0000_0010; memory returns 0x0000_0013 with ready in cycle 1.
  - Required: `instruction_ready` in cycle 2, data 0x0000_0013, memory mask 4'b1111, address 0x10.
- Byte store:
  - Stimulus: data WRITE, address 0x1000_0003, mask 4'b1000, data 0x41.
  - Required: memory address 0x1000_0000, mask 4'b1000, write data 0x41; `data_ready` pulse; `data_read_data` unchanged.
- Starvation limit:
  - Stimulus: both enables held high, `DATA_BURST_LIMIT`=4, memory always ready.
  - Required grant order: D,D,D,D,I,D,D,D,D,I; `burst_count` clears after each I.
- Wait states:
  - Stimulus: memory asserts ready 3 cycles after `memory_enable`; load from 0x100 returns 0xDEAD_BEEF.
  - Required: `data_ready` in cycle 4; `memory_*` stable through cycles 1–3.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=8, memory never ready.
  - Required: `data_ready` and `access_error` pulse in cycle 9; `data_read_data` unchanged; FSM back in IDLE; next request served normally.
- Reset mid-access:
  - Stimulus: `reset`=1 in cycle 2 of a 5-wait-state write.
  - Required: next cycle `memory_enable`=0; no `*_ready` pulse; counters 0; a fetch after reset completes in 2 cycles.

Source files
------------

// File: rtl/memory_interface_arbiter.sv
// Arbiter sharing one single-port word memory between the instruction fetch
// port (read-only) and the data port (read/write). Data requests win unless
// they have starved a pending fetch for DATA_BURST_LIMIT consecutive grants.
// Every access is bounded by a timeout so the core always makes progress.
module memory_interface_arbiter #(
  parameter int unsigned DATA_BURST_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        instruction_enable,
  input  logic [31:0] instruction_address,
  output logic        instruction_ready,
  output logic [31:0] instruction_read_data,

  input  logic        data_enable,
  input  logic        data_state,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_frame_mask,
  input  logic [31:0] data_write_data,
  output logic        data_ready,
  output logic [31:0] data_read_data,

  output logic        access_error,

  output logic        memory_enable,
  output logic        memory_state,
  output logic [31:0] memory_address,
  output logic [3:0]  memory_frame_mask,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data,
  input  logic        memory_ready
);

  localparam logic [3:0] BurstLimit  = 4'(DATA_BURST_LIMIT);
  // Abort fires on the cycle the counter would step up to TIMEOUT_CYCLES.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] WordMask   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e     state;
  logic [3:0] burst_count;
  logic [7:0] timeout_count;

  // Data wins a tie only while the fetch has not yet been starved.
  logic grant_data;
  assign grant_data = data_enable && !(instruction_enable && (burst_count == BurstLimit));

  // Single FSM: arbitration in IDLE, access tracking and timeout in BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= StIdle;
      burst_count           <= '0;
      timeout_count         <= '0;
      instruction_ready     <= 1'b0;
      instruction_read_data <= '0;
      data_ready            <= 1'b0;
      data_read_data        <= '0;
      access_error          <= 1'b0;
      memory_enable         <= 1'b0;
      memory_state          <= 1'b0;
      memory_address        <= '0;
      memory_frame_mask     <= '0;
      memory_write_data     <= '0;
    end else begin
      instruction_ready <= 1'b0;
      data_ready        <= 1'b0;
      access_error      <= 1'b0;

      unique case (state)
        StIdle: begin
          timeout_count <= '0;
          if (grant_data) begin
            memory_enable     <= 1'b1;
            memory_state      <= data_state;
            memory_address    <= data_address & WordMask;
            memory_frame_mask <= data_frame_mask;
            memory_write_data <= data_write_data;
            state             <= StBusyD;
            // grant_data already excludes the saturated case, so this
            // increment never passes the limit.
            if (instruction_enable) begin
              burst_count <= burst_count + 4'd1;
            end else begin
              burst_count <= '0;
            end
          end else if (instruction_enable) begin
            memory_enable     <= 1'b1;
            memory_state      <= 1'b0;
            memory_address    <= instruction_address & WordMask;
            memory_frame_mask <= 4'b1111;
            memory_write_data <= '0;
            burst_count       <= '0;
            state             <= StBusyI;
          end
        end

        StBusyI, StBusyD: begin
          if (memory_ready) begin
            if (state == StBusyI) begin
              instruction_ready     <= 1'b1;
              instruction_read_data <= memory_read_data;
            end else begin
              data_ready <= 1'b1;
              // Stores complete without disturbing the last loaded word.
              if (!memory_state) begin
                data_read_data <= memory_read_data;
              end
            end
            memory_enable <= 1'b0;
            timeout_count <= '0;
            state         <= StIdle;
          end else if (timeout_count == TimeoutLast) begin
            if (state == StBusyI) begin
              instruction_ready <= 1'b1;
            end else begin
              data_ready <= 1'b1;
            end
            access_error  <= 1'b1;
            memory_enable <= 1'b0;
            timeout_count <= '0;
            state         <= StIdle;
          end else begin
            timeout_count <= timeout_count + 8'd1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_interface_arbiter.sv
// Directed bench for memory_interface_arbiter: a behavioural word memory with
// configurable wait states, a stimulus process that pushes expected responses
// into a queue, and a monitor that pops and compares on each ready pulse.
module tb_memory_interface_arbiter;

  localparam int unsigned Limit = 4;
  localparam int unsigned Tmo   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instruction_enable = 1'b0;
  logic [31:0] instruction_address = '0;
  logic        instruction_ready;
  logic [31:0] instruction_read_data;
  logic        data_enable = 1'b0;
  logic        data_state = 1'b0;
  logic [31:0] data_address = '0;
  logic [3:0]  data_frame_mask = '0;
  logic [31:0] data_write_data = '0;
  logic        data_ready;
  logic [31:0] data_read_data;
  logic        access_error;
  logic        memory_enable;
  logic        memory_state;
  logic [31:0] memory_address;
  logic [3:0]  memory_frame_mask;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data = '0;
  logic        memory_ready = 1'b0;

  always #5 clk = ~clk;

  memory_interface_arbiter #(
    .DATA_BURST_LIMIT(Limit),
    .TIMEOUT_CYCLES  (Tmo)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction_enable   (instruction_enable),
    .instruction_address  (instruction_address),
    .instruction_ready    (instruction_ready),
    .instruction_read_data(instruction_read_data),
    .data_enable          (data_enable),
    .data_state           (data_state),
    .data_address         (data_address),
    .data_frame_mask      (data_frame_mask),
    .data_write_data      (data_write_data),
    .data_ready           (data_ready),
    .data_read_data       (data_read_data),
    .access_error         (access_error),
    .memory_enable        (memory_enable),
    .memory_state         (memory_state),
    .memory_address       (memory_address),
    .memory_frame_mask    (memory_frame_mask),
    .memory_write_data    (memory_write_data),
    .memory_read_data     (memory_read_data),
    .memory_ready         (memory_ready)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    bit          err;
    logic [31:0] addr;
    logic [3:0]  mask;
    bit          wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input bit is_data, input logic [31:0] data, input bit err,
                          input logic [31:0] addr, input logic [3:0] mask, input bit wr,
                          input logic [31:0] wdata);
    exp_t e;
    e.is_data = is_data; e.data = data; e.err = err; e.addr = addr;
    e.mask = mask; e.wr = wr; e.wdata = wdata;
    expq.push_back(e);
  endtask

  // Behavioural memory: ready in the (wait_cycles+1)-th cycle of memory_enable.
  logic [31:0] mem [int unsigned];
  int          wait_cycles = 0;
  bit          never_ready = 1'b0;
  int          busy = 0;
  logic [31:0] cur_word;
  int unsigned widx;

  always @(posedge clk) begin
    #1;
    if (memory_enable) busy++; else busy = 0;
    memory_ready     = 1'b0;
    memory_read_data = 32'hBAD0_BAD0;
    if (memory_enable && !never_ready && busy == wait_cycles + 1) begin
      memory_ready = 1'b1;
      widx = memory_address >> 2;
      cur_word = mem.exists(widx) ? mem[widx] : 32'h0;
      memory_read_data = cur_word;
      if (memory_state) begin
        for (int k = 0; k < 4; k++)
          if (memory_frame_mask[k]) cur_word[8*(3-k) +: 8] = memory_write_data[8*(3-k) +: 8];
        mem[widx] = cur_word;
      end
    end
  end

  // Monitor: memory-side stability while busy, response check on each ready.
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_mask;
  logic        lat_state;
  bit          prev_en = 1'b0;
  exp_t        me;

  always @(negedge clk) begin
    if (memory_enable && !prev_en) begin
      lat_addr = memory_address; lat_wdata = memory_write_data;
      lat_mask = memory_frame_mask; lat_state = memory_state;
    end else if (memory_enable) begin
      chk("mem_addr_stable", memory_address, lat_addr);
      chk("mem_mask_stable", memory_frame_mask, lat_mask);
      chk("mem_state_stable", memory_state, lat_state);
      chk("mem_wdata_stable", memory_write_data, lat_wdata);
    end
    if (instruction_ready || data_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=i%0b/d%0b required=none",
                 instruction_ready, data_ready);
      end else begin
        me = expq.pop_front();
        chk("resp_kind", {data_ready, instruction_ready}, {me.is_data, !me.is_data});
        chk("resp_data", me.is_data ? data_read_data : instruction_read_data, me.data);
        chk("access_error", access_error, me.err);
        chk("mem_addr", lat_addr, me.addr);
        chk("mem_mask", lat_mask, me.mask);
        chk("mem_state", lat_state, me.wr);
        if (me.wr) chk("mem_wdata", lat_wdata, me.wdata);
        chk("mem_enable_drop", memory_enable, 1'b0);
      end
    end
    prev_en = memory_enable;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits for the chosen ready pulse and checks the cycle count since issue.
  task automatic wait_resp(input string name, input bit want_data, input int req_lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = want_data ? data_ready : instruction_ready;
    end
    chk({name, "_latency"}, n, req_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int got;
    int n;

    mem[32'h10 >> 2]        = 32'h0000_0013;
    mem[32'h100 >> 2]       = 32'hDEAD_BEEF;
    mem[32'h200 >> 2]       = 32'h1111_2222;
    mem[32'h300 >> 2]       = 32'h3333_4444;
    mem[32'h404 >> 2]       = 32'h5555_6666;
    mem[32'h1000_0000 >> 2] = 32'hAABB_CCDD;

    // Reset state
    tick(); tick();
    chk("rst_instruction_ready", instruction_ready, 1'b0);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_access_error", access_error, 1'b0);
    chk("rst_memory_enable", memory_enable, 1'b0);
    chk("rst_memory_address", memory_address, 32'h0);
    chk("rst_memory_mask", memory_frame_mask, 4'h0);
    chk("rst_data_read_data", data_read_data, 32'h0);
    chk("rst_burst_count", dut.burst_count, 4'h0);
    reset = 1'b0;
    tick();

    // Single fetch
    push_exp(1'b0, 32'h0000_0013, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0);
    instruction_address = 32'h10;
    instruction_enable  = 1'b1;
    wait_resp("fetch", 1'b0, 2);
    instruction_enable = 1'b0;
    tick();

    // Load with two wait states
    wait_cycles = 2;
    push_exp(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h100, 4'hF, 1'b0, 32'h0);
    data_state = 1'b0; data_address = 32'h100; data_frame_mask = 4'hF;
    data_enable = 1'b1;
    wait_resp("wait_load", 1'b1, 4);
    data_enable = 1'b0;
    wait_cycles = 0;
    tick();

    // Byte store: read data must keep the previous load
    push_exp(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h1000_0000, 4'b1000, 1'b1, 32'h41);
    data_state = 1'b1; data_address = 32'h1000_0003; data_frame_mask = 4'b1000;
    data_write_data = 32'h41;
    data_enable = 1'b1;
    wait_resp("store", 1'b1, 2);
    data_enable = 1'b0;
    tick();
    chk("store_mem_word", mem[32'h1000_0000 >> 2], 32'hAABB_CC41);

    // Starvation limit: D,D,D,D,I repeated
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++)
        push_exp(1'b1, 32'h1111_2222, 1'b0, 32'h200, 4'hF, 1'b0, 32'h0);
      push_exp(1'b0, 32'h3333_4444, 1'b0, 32'h300, 4'hF, 1'b0, 32'h0);
    end
    data_state = 1'b0; data_address = 32'h200; data_frame_mask = 4'hF;
    instruction_address = 32'h300;
    data_enable = 1'b1;
    instruction_enable = 1'b1;
    got = 0;
    n = 0;
    while (got < 10 && n < 100) begin
      tick();
      n++;
      if (instruction_ready || data_ready) begin
        got++;
        if (instruction_ready) chk("burst_clear", dut.burst_count, 4'h0);
        if (got == 10) begin
          data_enable = 1'b0;
          instruction_enable = 1'b0;
        end
      end
    end
    chk("burst_responses", got, 10);
    tick();

    // Timeout: memory never answers
    never_ready = 1'b1;
    push_exp(1'b1, 32'h1111_2222, 1'b1, 32'h400, 4'hF, 1'b0, 32'h0);
    data_address = 32'h400;
    data_enable = 1'b1;
    wait_resp("timeout", 1'b1, Tmo + 1);
    data_enable = 1'b0;
    never_ready = 1'b0;
    tick();
    chk("timeout_count_clear", dut.timeout_count, 8'h0);
    chk("timeout_idle_enable", memory_enable, 1'b0);
    push_exp(1'b1, 32'h5555_6666, 1'b0, 32'h404, 4'hF, 1'b0, 32'h0);
    data_address = 32'h404;
    data_enable = 1'b1;
    wait_resp("after_timeout", 1'b1, 2);
    data_enable = 1'b0;
    tick();

    // Reset in the middle of a five-wait-state write
    wait_cycles = 5;
    data_state = 1'b1; data_address = 32'h500; data_frame_mask = 4'hF;
    data_write_data = 32'h1234_5678;
    data_enable = 1'b1;
    tick();
    chk("midrst_enable_high", memory_enable, 1'b1);
    tick();
    reset = 1'b1;
    data_enable = 1'b0;
    tick();
    chk("midrst_enable_low", memory_enable, 1'b0);
    chk("midrst_burst", dut.burst_count, 4'h0);
    chk("midrst_timeout", dut.timeout_count, 8'h0);
    chk("midrst_read_data", data_read_data, 32'h0);
    chk("midrst_data_ready", data_ready, 1'b0);
    reset = 1'b0;
    wait_cycles = 0;
    tick(); tick();
    chk("midrst_write_abandoned", mem.exists(32'h500 >> 2), 1'b0);
    push_exp(1'b0, 32'h0000_0013, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0);
    instruction_address = 32'h10;
    instruction_enable = 1'b1;
    wait_resp("post_reset_fetch", 1'b0, 2);
    instruction_enable = 1'b0;
    tick(); tick();

    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
